// File: rtl/pl_pkg.sv
// Shared definitions for the 5-stage RV32I pipeline controller:
// opcodes, the bubble instruction, FSM states and write-back select codes.
package pl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        RUN      = 2'd1,
        LU_STALL = 2'd2
    } state_t;

    localparam logic [1:0] WB_DMEM = 2'd0;
    localparam logic [1:0] WB_ALU  = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

endpackage

// File: rtl/pl_hz_detect.sv
// Combinational load-use detector: a valid load in X whose destination
// is a source register actually read by the instruction sitting in D.
module pl_hz_detect
    import pl_pkg::*;
(
    input  logic [31:0] inst_d,
    input  logic [31:0] inst_x,
    input  logic        v_x,
    output logic        lu_hit
);

    logic [6:0] op_d;
    logic [6:0] op_x;
    logic [4:0] rd_x;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic       use_rs1;
    logic       use_rs2;
    logic       unused_bits;

    assign op_d  = inst_d[6:0];
    assign op_x  = inst_x[6:0];
    assign rd_x  = inst_x[11:7];
    assign rs1_d = inst_d[19:15];
    assign rs2_d = inst_d[24:20];

    // Fields that never take part in the comparison
    assign unused_bits = ^{inst_d[31:25], inst_d[14:7], inst_x[31:12]};

    // Which source operands the D instruction really reads
    always_comb begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        case (op_d)
            OP_LUI, OP_AUIPC, OP_JAL:     use_rs1 = 1'b0;
            default:                      use_rs1 = 1'b1;
        endcase
        case (op_d)
            OP_RTYPE, OP_STORE, OP_BRANCH: use_rs2 = 1'b1;
            default:                       use_rs2 = 1'b0;
        endcase
    end

    // x0 is never a real dependency, so a load to x0 cannot stall
    always_comb begin
        lu_hit = 1'b0;
        if ((op_x == OP_LOAD) && (rd_x != 5'd0) && v_x) begin
            lu_hit = ((rd_x == rs1_d) && use_rs1) ||
                     ((rd_x == rs2_d) && use_rs2);
        end
    end

endmodule

// File: rtl/pl_hazard_sequencer.sv
// Pipeline controller for the F/D/X/M/W RV32I datapath: load-use stall,
// branch/jump flush, X->M->W control staging and bring-up event counters.
module pl_hazard_sequencer
    import pl_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_INST = pl_pkg::NOP_INST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_d,
    input  logic [31:0]      inst_x,
    input  logic             br_taken,
    input  logic             x_regwen,
    input  logic [1:0]       x_wbsel,
    input  logic             x_memrw,
    output logic             pc_en,
    output logic             instd_en,
    output logic             instd_flush,
    output logic             instx_bubble,
    output logic             m_regwen,
    output logic             m_memrw,
    output logic [1:0]       m_wbsel,
    output logic             w_regwen,
    output logic [1:0]       w_wbsel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t state;
    state_t state_next;

    logic v_x;
    logic v_m;
    logic v_w;
    logic bubble_prev;
    logic lu_hit;
    logic x_is_bubble;
    logic flush;
    logic lu_act;

    pl_hz_detect u_hz_detect (
        .inst_d (inst_d),
        .inst_x (inst_x),
        .v_x    (v_x),
        .lu_hit (lu_hit)
    );

    // The injected bubble never counts as a load, even if NOP_INST is
    // overridden with a pattern that happens to decode as one.
    assign x_is_bubble = (inst_x == NOP_INST);

    // Register enables, flush/bubble requests and FSM next state
    always_comb begin
        flush        = 1'b0;
        lu_act       = 1'b0;
        pc_en        = 1'b0;
        instd_en     = 1'b0;
        instd_flush  = 1'b0;
        instx_bubble = 1'b0;
        state_next   = state;
        if (!rst) begin
            // A redirect out of X wins over a load-use in the same cycle
            flush        = br_taken & v_x;
            lu_act       = lu_hit & ~x_is_bubble & ~flush & (state != LU_STALL);
            pc_en        = ~lu_act;
            instd_en     = ~lu_act;
            instd_flush  = flush;
            instx_bubble = flush | lu_act;
            case (state)
                FILL: begin
                    if (lu_act) begin
                        state_next = LU_STALL;
                    end else if (v_m) begin
                        // v_w turns on at this edge: the pipe is full
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (lu_act) begin
                        state_next = LU_STALL;
                    end
                end
                LU_STALL: state_next = RUN;
                default:  state_next = FILL;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Stage-valid bits; a bubble or flush carries v=0 down the pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            v_x         <= 1'b0;
            v_m         <= 1'b0;
            v_w         <= 1'b0;
            bubble_prev <= 1'b0;
        end else begin
            if (instx_bubble) begin
                v_x <= 1'b0;
            end else if (instd_en) begin
                v_x <= ~instd_flush;
            end
            v_m         <= v_x & ~bubble_prev;
            v_w         <= v_m;
            bubble_prev <= instx_bubble;
        end
    end

    // X -> M -> W control staging, gated by the X valid bit
    always_ff @(posedge clk) begin
        if (rst) begin
            m_regwen <= 1'b0;
            m_memrw  <= 1'b0;
            m_wbsel  <= 2'd0;
            w_regwen <= 1'b0;
            w_wbsel  <= 2'd0;
        end else begin
            m_regwen <= x_regwen & v_x;
            m_memrw  <= x_memrw & v_x;
            m_wbsel  <= x_wbsel & {2{v_x}};
            w_regwen <= m_regwen;
            w_wbsel  <= m_wbsel;
        end
    end

    // Saturating stall/flush event counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (lu_act && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pl_hazard_sequencer.sv
// Self-checking bench for pl_hazard_sequencer: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_pl_hazard_sequencer;
    import pl_pkg::*;

    localparam int CW = 4;
    localparam int LIM = (1 << CW) - 1;

    localparam logic [31:0] LW_X5  = 32'h0000A283;  // lw  x5,0(x1)
    localparam logic [31:0] ADD_X5 = 32'h00228333;  // add x6,x5,x2
    localparam logic [31:0] LW_X0  = 32'h0000A003;  // lw  x0,0(x1)
    localparam logic [31:0] ADD_X0 = 32'h00200333;  // add x6,x0,x2
    localparam logic [31:0] BEQ    = 32'h00000063;  // beq x0,x0,0

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [31:0]   inst_d = NOP_INST;
    logic [31:0]   inst_x = NOP_INST;
    logic          br_taken = 1'b0;
    logic          x_regwen = 1'b0;
    logic [1:0]    x_wbsel = WB_ALU;
    logic          x_memrw = 1'b0;
    logic          pc_en, instd_en, instd_flush, instx_bubble;
    logic          m_regwen, m_memrw, w_regwen;
    logic [1:0]    m_wbsel, w_wbsel;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pl_hazard_sequencer #(.CNT_W(CW), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rst(rst), .inst_d(inst_d), .inst_x(inst_x),
        .br_taken(br_taken), .x_regwen(x_regwen), .x_wbsel(x_wbsel),
        .x_memrw(x_memrw), .pc_en(pc_en), .instd_en(instd_en),
        .instd_flush(instd_flush), .instx_bubble(instx_bubble),
        .m_regwen(m_regwen), .m_memrw(m_memrw), .m_wbsel(m_wbsel),
        .w_regwen(w_regwen), .w_wbsel(w_wbsel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state
    bit       mv_x, mv_m, mv_w, m_bprev, m_stall, m_fill;
    bit       m_mr, m_mm, m_wr;
    bit [1:0] m_mw, m_ww;
    int       m_scnt, m_fcnt;
    bit       e_pc, e_den, e_dfl, e_bub, e_lu;

    function automatic bit is_hazard(logic [31:0] x, logic [31:0] d, bit vx);
        logic [6:0] opd;
        bit u1, u2;
        opd = d[6:0];
        u1 = !(opd == 7'b0110111 || opd == 7'b0010111 || opd == 7'b1101111);
        u2 = (opd == 7'b0110011 || opd == 7'b0100011 || opd == 7'b1100011);
        return (x[6:0] == 7'b0000011) && (x[11:7] != 5'd0) && vx &&
               (((x[11:7] == d[19:15]) && u1) || ((x[11:7] == d[24:20]) && u2));
    endfunction

    function automatic state_t exp_state();
        if (m_fill)  return FILL;
        if (m_stall) return LU_STALL;
        return RUN;
    endfunction

    // Expected combinational outputs for the current inputs
    function automatic void model_comb();
        e_dfl = !rst && br_taken && mv_x;
        e_lu  = !rst && !e_dfl && !m_stall && is_hazard(inst_x, inst_d, mv_x);
        e_bub = e_dfl || e_lu;
        e_pc  = !rst && !e_lu;
        e_den = e_pc;
    endfunction

    // Model state advance across one rising edge
    function automatic void model_next();
        bit nvx;
        model_comb();
        if (rst) begin
            mv_x = 0; mv_m = 0; mv_w = 0; m_bprev = 0; m_stall = 0; m_fill = 1;
            m_mr = 0; m_mm = 0; m_wr = 0; m_mw = 0; m_ww = 0; m_scnt = 0; m_fcnt = 0;
        end else begin
            nvx = e_bub ? 1'b0 : (e_den ? !e_dfl : mv_x);
            m_fill = m_fill && !e_lu && !mv_m;
            m_wr = m_mr; m_ww = m_mw;
            m_mr = x_regwen && mv_x;
            m_mm = x_memrw && mv_x;
            m_mw = mv_x ? x_wbsel : 2'd0;
            mv_w = mv_m; mv_m = mv_x && !m_bprev; mv_x = nvx;
            m_bprev = e_bub; m_stall = e_lu;
            if (e_lu && m_scnt < LIM) m_scnt++;
            if (e_dfl && m_fcnt < LIM) m_fcnt++;
        end
    endfunction

    task automatic drive(input bit r, input logic [31:0] d, input logic [31:0] x,
                         input bit br, input bit rw, input logic [1:0] ws, input bit mw);
        @(posedge clk);
        model_next();
        @(negedge clk);
        rst = r; inst_d = d; inst_x = x; br_taken = br;
        x_regwen = rw; x_wbsel = ws; x_memrw = mw;
        #1;
        model_comb();
    endtask

    task automatic do_reset();
        drive(1, NOP_INST, NOP_INST, 0, 0, WB_ALU, 0);
        drive(1, NOP_INST, NOP_INST, 0, 0, WB_ALU, 0);
        repeat (4) drive(0, NOP_INST, NOP_INST, 0, 0, WB_ALU, 0);
    endtask

    task automatic test_reset();
        drive(1, NOP_INST, NOP_INST, 0, 1, WB_ALU, 0);
        drive(1, NOP_INST, NOP_INST, 0, 1, WB_ALU, 0);
        n_vec++; if (pc_en !== 1'b0) begin n_bad++; $display("FAIL rst_pc_en got %0b want 0", pc_en); end
        n_vec++; if (instd_en !== 1'b0) begin n_bad++; $display("FAIL rst_instd_en got %0b want 0", instd_en); end
        n_vec++; if (stall_cnt !== '0 || flush_cnt !== '0) begin n_bad++; $display("FAIL rst_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        n_vec++; if (w_regwen !== 1'b0) begin n_bad++; $display("FAIL rst_w_regwen got %0b want 0", w_regwen); end
        for (int k = 0; k < 5; k++) begin
            drive(0, NOP_INST, NOP_INST, 0, 1, WB_ALU, 0);
            n_vec++; if (pc_en !== 1'b1 || instd_en !== 1'b1) begin n_bad++; $display("FAIL rel_en k=%0d got %0b%0b want 11", k, pc_en, instd_en); end
            n_vec++; if (w_regwen !== (k >= 3)) begin n_bad++; $display("FAIL rel_w_regwen k=%0d got %0b want %0b", k, w_regwen, k >= 3); end
            n_vec++; if (dut.state !== ((k >= 3) ? RUN : FILL)) begin n_bad++; $display("FAIL rel_state k=%0d got %0d want %0d", k, dut.state, (k >= 3) ? RUN : FILL); end
            n_vec++; if (stall_cnt !== '0 || flush_cnt !== '0) begin n_bad++; $display("FAIL rel_cnt k=%0d got %0d/%0d want 0/0", k, stall_cnt, flush_cnt); end
        end
    endtask

    task automatic test_load_use_rs1();
        do_reset();
        drive(0, ADD_X5, LW_X5, 0, 1, WB_DMEM, 0);
        n_vec++; if ({pc_en, instd_en, instx_bubble, instd_flush} !== 4'b0010) begin n_bad++; $display("FAIL lu_detect got %b want 0010", {pc_en, instd_en, instx_bubble, instd_flush}); end
        drive(0, ADD_X5, NOP_INST, 0, 1, WB_ALU, 0);
        n_vec++; if ({pc_en, instd_en, instx_bubble} !== 3'b110) begin n_bad++; $display("FAIL lu_stall_cyc got %b want 110", {pc_en, instd_en, instx_bubble}); end
        n_vec++; if (stall_cnt !== 4'd1) begin n_bad++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt); end
        n_vec++; if (dut.state !== LU_STALL) begin n_bad++; $display("FAIL lu_state got %0d want %0d", dut.state, LU_STALL); end
        drive(0, NOP_INST, ADD_X5, 0, 1, WB_ALU, 0);
        n_vec++; if (dut.state !== RUN || pc_en !== 1'b1) begin n_bad++; $display("FAIL lu_return got st=%0d pc_en=%0b want st=%0d pc_en=1", dut.state, pc_en, RUN); end
        n_vec++; if (stall_cnt !== 4'd1) begin n_bad++; $display("FAIL lu_cnt_hold got %0d want 1", stall_cnt); end
    endtask

    task automatic test_load_x0();
        do_reset();
        drive(0, ADD_X0, LW_X0, 0, 1, WB_DMEM, 0);
        n_vec++; if (pc_en !== 1'b1 || instx_bubble !== 1'b0) begin n_bad++; $display("FAIL x0_nostall got pc_en=%0b bub=%0b want 1/0", pc_en, instx_bubble); end
        drive(0, NOP_INST, NOP_INST, 0, 0, WB_ALU, 0);
        n_vec++; if (stall_cnt !== 4'd0 || dut.state !== RUN) begin n_bad++; $display("FAIL x0_cnt got %0d st=%0d want 0 st=%0d", stall_cnt, dut.state, RUN); end
    endtask

    task automatic test_branch();
        do_reset();
        drive(0, NOP_INST, BEQ, 1, 0, WB_ALU, 0);
        n_vec++; if ({instd_flush, instx_bubble, pc_en, instd_en} !== 4'b1111) begin n_bad++; $display("FAIL br_outs got %b want 1111", {instd_flush, instx_bubble, pc_en, instd_en}); end
        drive(0, NOP_INST, NOP_INST, 0, 1, WB_ALU, 1);
        n_vec++; if (flush_cnt !== 4'd1) begin n_bad++; $display("FAIL br_cnt got %0d want 1", flush_cnt); end
        n_vec++; if (m_regwen !== 1'b0 || w_regwen !== 1'b0) begin n_bad++; $display("FAIL br_edge1 got m=%0b w=%0b want 0/0", m_regwen, w_regwen); end
        drive(0, NOP_INST, NOP_INST, 0, 1, WB_ALU, 1);
        n_vec++; if (m_regwen !== 1'b0 || w_regwen !== 1'b0 || m_memrw !== 1'b0) begin n_bad++; $display("FAIL br_edge2 got m=%0b w=%0b mw=%0b want 0/0/0", m_regwen, w_regwen, m_memrw); end
        drive(0, NOP_INST, NOP_INST, 0, 1, WB_ALU, 1);
        n_vec++; if (m_regwen !== 1'b1 || m_memrw !== 1'b1) begin n_bad++; $display("FAIL br_resume got m=%0b mw=%0b want 1/1", m_regwen, m_memrw); end
    endtask

    task automatic test_flush_and_lu();
        do_reset();
        drive(0, ADD_X5, LW_X5, 1, 1, WB_DMEM, 0);
        n_vec++; if ({instd_flush, instx_bubble, pc_en, instd_en} !== 4'b1111) begin n_bad++; $display("FAIL fl_lu_outs got %b want 1111", {instd_flush, instx_bubble, pc_en, instd_en}); end
        drive(0, NOP_INST, NOP_INST, 0, 0, WB_ALU, 0);
        n_vec++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd1) begin n_bad++; $display("FAIL fl_lu_cnt got %0d/%0d want 0/1", stall_cnt, flush_cnt); end
        n_vec++; if (dut.state !== RUN) begin n_bad++; $display("FAIL fl_lu_state got %0d want %0d", dut.state, RUN); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(0, ADD_X5, LW_X5, 0, 1, WB_DMEM, 0);
            n_vec++; if (instx_bubble !== 1'b1) begin n_bad++; $display("FAIL sat_bub i=%0d got %0b want 1", i, instx_bubble); end
            drive(0, ADD_X5, LW_X5, 0, 1, WB_DMEM, 0);
            n_vec++; if (stall_cnt !== CW'((i + 1 > LIM) ? LIM : i + 1)) begin n_bad++; $display("FAIL sat_cnt i=%0d got %0d want %0d", i, stall_cnt, (i + 1 > LIM) ? LIM : i + 1); end
        end
        drive(1, NOP_INST, NOP_INST, 0, 0, WB_ALU, 0);
        drive(0, NOP_INST, NOP_INST, 0, 0, WB_ALU, 0);
        n_vec++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL sat_clear got %0d want 0", stall_cnt); end
    endtask

    task automatic test_random();
        logic [6:0]  ops [10];
        logic [1:0]  wbs [3];
        logic [31:0] d, x;
        ops = '{OP_LOAD, OP_LOAD, OP_STORE, OP_BRANCH, OP_RTYPE, OP_LUI,
                OP_AUIPC, OP_JAL, OP_JALR, 7'b0010011};
        wbs = '{WB_DMEM, WB_ALU, WB_PC4};
        do_reset();
        for (int c = 0; c < 400; c++) begin
            d = {7'd0, 3'd0, 2'($urandom), 3'd0, 2'($urandom), 3'b010, 3'd0, 2'($urandom), ops[$urandom_range(0, 9)]};
            x = {7'd0, 3'd0, 2'($urandom), 3'd0, 2'($urandom), 3'b010, 3'd0, 2'($urandom), ops[$urandom_range(0, 9)]};
            drive($urandom_range(0, 49) == 0, d, x, $urandom_range(0, 3) == 0,
                  1'($urandom), wbs[$urandom_range(0, 2)], 1'($urandom));
            n_vec++; if ({pc_en, instd_en, instd_flush, instx_bubble} !== {e_pc, e_den, e_dfl, e_bub}) begin n_bad++; $display("FAIL rnd_ctl c=%0d got %b want %b", c, {pc_en, instd_en, instd_flush, instx_bubble}, {e_pc, e_den, e_dfl, e_bub}); end
            n_vec++; if ({m_regwen, m_memrw, m_wbsel} !== {m_mr, m_mm, m_mw}) begin n_bad++; $display("FAIL rnd_m c=%0d got %b want %b", c, {m_regwen, m_memrw, m_wbsel}, {m_mr, m_mm, m_mw}); end
            n_vec++; if ({w_regwen, w_wbsel} !== {m_wr, m_ww}) begin n_bad++; $display("FAIL rnd_w c=%0d got %b want %b", c, {w_regwen, w_wbsel}, {m_wr, m_ww}); end
            n_vec++; if (stall_cnt !== CW'(m_scnt) || flush_cnt !== CW'(m_fcnt)) begin n_bad++; $display("FAIL rnd_cnt c=%0d got %0d/%0d want %0d/%0d", c, stall_cnt, flush_cnt, m_scnt, m_fcnt); end
            n_vec++; if (dut.state !== exp_state()) begin n_bad++; $display("FAIL rnd_state c=%0d got %0d want %0d", c, dut.state, exp_state()); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use_rs1();
        test_load_x0();
        test_branch();
        test_flush_and_lu();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pl_hazard_sequencer.md
Name: pl_hazard_sequencer

Overview:
- Pipeline controller for the 5-stage RV32I datapath (F/D/X/M/W with X-stage forwarding).
- Detects load-use hazards and stalls F/D while injecting an X bubble.
- On a taken branch or jump resolved in X, flushes D and X.
- Stages the per-instruction control bits (regwen, wbsel, memrw) from X to M to W, gated by stage-valid bits.
- Keeps saturating stall and flush counters for bring-up.

Parameters:
- CNT_W, 16, width of the stall and flush event counters (saturating).
- NOP_INST, 32'h00000013, instruction word loaded into X on a bubble (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_d  in  32  instruction in the D register (regfile read stage).
- inst_x  in  32  instruction in the X register.
- br_taken  in  1  X-stage redirect (taken branch, JAL or JALR); same as PC-mux select.
- x_regwen  in  1  decoded regwen for the X instruction.
- x_wbsel  in  2  decoded wbsel for the X instruction.
- x_memrw  in  1  decoded dmem write enable for the X instruction.
- pc_en  out  1  PC register load enable.
- instd_en  out  1  D-register load enable.
- instd_flush  out  1  load NOP_INST into D at the next edge.
- instx_bubble  out  1  load NOP_INST into X and zero X control at the next edge.
- m_regwen, m_memrw  out  1 each  M-stage control, valid-gated.
- m_wbsel  out  2  M-stage wbsel.
- w_regwen  out  1  W-stage regwen, valid-gated; drives regfile regwen.
- w_wbsel  out  2  W-stage wbsel.
- stall_cnt, flush_cnt  out  CNT_W each  event counters.

Behaviour:
- Clock and reset: one clock domain. Synchronous active-high reset. All state updates on the rising edge of clk.
- Reset values: all registered outputs 0, counters 0, v_x/v_m/v_w = 0, FSM in FILL.
- While rst=1: pc_en=0, instd_en=0.
- FSM states:
  - FILL: entered from reset. Leaves to RUN once v_w first becomes 1 (3 edges after rst deasserts).
  - RUN: normal operation.
  - LU_STALL: exactly one cycle. Always returns to RUN.
- Register controls in FILL: pc_en=1, instd_en=1. Invalid stages have regwen and memrw forced to 0.
- Load-use detect (combinational):
  - Condition: inst_x[6:0]==7'b0000011, and rd_x!=0, and v_x=1, and either:
    - rd_x==rs1_d, and inst_d uses rs1 (every opcode except LUI, AUIPC, JAL); or
    - rd_x==rs2_d, and inst_d uses rs2 (opcodes 0110011, 0100011, 1100011).
- On load-use in RUN or FILL:
  - pc_en=0, instd_en=0, instx_bubble=1, go to LU_STALL.
  - stall_cnt increments.
- In LU_STALL:
  - pc_en=1, instd_en=1, no bubble. The dependent instruction enters X at the next edge, and the W forwarding path supplies the load data.
  - A load-use detect is ignored in LU_STALL, because inst_x is then the bubble.
- Flush:
  - br_taken=1 with v_x=1 gives instd_flush=1 and instx_bubble=1. pc_en=1 and instd_en=1 so the redirected PC loads.
  - flush_cnt increments.
- Priority: flush beats load-use. If both are asserted in the same cycle, only the flush is acted on, the state stays RUN, and stall_cnt does not increment.
- Valid pipeline:
  - Loaded at each edge: v_x <= instd_en ? ~instd_flush : v_x, then forced to 0 when instx_bubble=1.
  - v_m <= v_x & ~instx_bubble_prev. A bubble carries v=0 downstream.
  - v_w <= v_m.
- Control staging, one register stage each:
  - m_* <= x_* & v_x
  - w_regwen <= m_regwen
  - w_wbsel <= m_wbsel
  - Latency from X to W is 2 edges.
- Counters: saturate at all-ones and never wrap. Both are cleared only by rst.
- Reset mid-stall or mid-flush: rst overrides everything at the next edge. The FSM returns to FILL and all valid bits clear.

Decomposition:
- Shared package pl_pkg holds:
  - opcode constants: OP_LOAD, OP_STORE, OP_BRANCH, OP_RTYPE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR;
  - NOP_INST;
  - the FSM state enum (FILL, RUN, LU_STALL);
  - wbsel encodings (0 dmem, 1 alu, 2 pc+4).
- One sub-module, pl_hz_detect: purely combinational load-use detect.
  - Inputs: inst_d, inst_x, v_x.
  - Output: lu_hit.
  - Instantiated once.

Test Plan:
- Reset release: rst high 2 cycles, then low. Expect pc_en=1 in the first cycle after release, w_regwen=0 until v_w=1, FSM reaches RUN after 3 edges, both counters 0.
- Load-use on rs1: X=lw x5,0(x1) (32'h0000A283), D=add x6,x5,x2 (32'h00228333). Expect pc_en=0, instd_en=0, instx_bubble=1 for exactly 1 cycle, stall_cnt=1, and the next cycle returns to RUN with pc_en=1.
- Load to x0: X=lw x0,0(x1), D=add x6,x0,x2. Expect no stall and stall_cnt unchanged.
- Taken branch: br_taken=1 with v_x=1. Expect instd_flush=1, instx_bubble=1, flush_cnt=1, and m_regwen=0 and w_regwen=0 for the two following edges.
- Simultaneous flush and load-use (forced stimulus): expect only the flush outputs, stall_cnt unchanged, state RUN.
- Counter saturation with CNT_W=4: 20 back-to-back load-use pairs. Expect stall_cnt to hold at 4'hF, then rst clears it to 0.
